// File: rtl/graphics_pkg.sv
// Shared types and defaults for the sprite drawing path.
package graphics_pkg;

    localparam int FRAME_WIDTH_DEFAULT  = 640;
    localparam int FRAME_HEIGHT_DEFAULT = 400;

    typedef enum logic [1:0] {
        BPP_1     = 2'd0,
        BPP_2     = 2'd1,
        BPP_4     = 2'd2,
        BPP_4_ALT = 2'd3
    } bpp_mode_t;

    typedef logic [1:0] sprite_state_t;

    localparam sprite_state_t ST_IDLE  = 2'd0;
    localparam sprite_state_t ST_FETCH = 2'd1;
    localparam sprite_state_t ST_DRAW  = 2'd2;
    localparam sprite_state_t ST_DONE  = 2'd3;

    function automatic logic [3:0] fields_per_byte(input bpp_mode_t mode);
        case (mode)
            BPP_1:   return 4'd8;
            BPP_2:   return 4'd4;
            default: return 4'd2;
        endcase
    endfunction

endpackage

// File: rtl/sprite_pixel_unpacker.sv
// Splits a packed pixel byte into 1/2/4-bit fields, least-significant field first.
module sprite_pixel_unpacker
    import graphics_pkg::*;
(
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       load,
    input  logic [7:0] byte_data,
    input  bpp_mode_t  bpp_mode,
    input  logic       step,
    output logic [3:0] field,
    output logic       last_field
);

    logic [7:0] shift_reg;
    logic [3:0] fields_left;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            shift_reg   <= 8'd0;
            fields_left <= 4'd0;
        end else if (load) begin
            shift_reg   <= byte_data;
            fields_left <= fields_per_byte(bpp_mode);
        end else if (step && fields_left != 4'd0) begin
            case (bpp_mode)
                BPP_1:   shift_reg <= shift_reg >> 1;
                BPP_2:   shift_reg <= shift_reg >> 2;
                default: shift_reg <= shift_reg >> 4;
            endcase
            fields_left <= fields_left - 4'd1;
        end
    end

    always_comb begin
        case (bpp_mode)
            BPP_1:   field = {3'd0, shift_reg[0]};
            BPP_2:   field = {2'd0, shift_reg[1:0]};
            default: field = shift_reg[3:0];
        endcase
    end

    assign last_field = (fields_left == 4'd1);

endmodule

// File: rtl/sprite_blitter.sv
// Draws a packed-index sprite into the frame buffer with clipping, transparency and backpressure.
//   state | meaning
//   IDLE  | waiting for start_in
//   FETCH | data_ready_out high, waiting for the next packed byte
//   DRAW  | one field per cycle; holds while a write is refused
//   DONE  | done_out pulse, back to IDLE
module sprite_blitter
    import graphics_pkg::*;
#(
    parameter  int FRAME_WIDTH  = FRAME_WIDTH_DEFAULT,
    parameter  int FRAME_HEIGHT = FRAME_HEIGHT_DEFAULT,
    parameter  int PIXEL_WIDTH  = 4,
    localparam int ADDR_WIDTH   = $clog2(FRAME_WIDTH * FRAME_HEIGHT)
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   enable_in,
    input  logic                   start_in,
    input  logic [9:0]             x_position_in,
    input  logic [9:0]             y_position_in,
    input  logic [9:0]             width_in,
    input  logic [9:0]             height_in,
    input  logic [1:0]             bpp_mode_in,
    input  logic [PIXEL_WIDTH-1:0] color_palette_offset_in,
    input  logic                   transparent_enable_in,
    input  logic                   data_valid_in,
    output logic                   data_ready_out,
    input  logic [7:0]             data_in,
    output logic                   pixel_write_enable_out,
    input  logic                   pixel_write_ready_in,
    output logic [ADDR_WIDTH-1:0]  pixel_write_address_out,
    output logic [PIXEL_WIDTH-1:0] pixel_write_data_out,
    output logic                   busy_out,
    output logic                   done_out
);

    sprite_state_t          state;
    logic [9:0]             x_pos, y_pos, width, height, rx, ry, ry_next;
    bpp_mode_t              bpp;
    logic [PIXEL_WIDTH-1:0] offset;
    logic                   transparent;

    logic [3:0]             field;
    logic                   last_field;
    logic                   out_free, draw_step, byte_load, row_end, in_frame, write_ok;
    logic [10:0]            x_abs, y_abs;
    logic [ADDR_WIDTH-1:0]  pixel_address;
    logic [PIXEL_WIDTH-1:0] pixel_value;

    assign data_ready_out = (state == ST_FETCH);
    assign busy_out       = (state != ST_IDLE);

    // The output register is free once nothing is pending or the pending write is taken this edge.
    assign out_free  = !pixel_write_enable_out || pixel_write_ready_in;
    assign byte_load = enable_in && (state == ST_FETCH) && data_valid_in;
    assign draw_step = enable_in && (state == ST_DRAW) && (ry != height) && out_free;

    assign x_abs         = {1'b0, x_pos} + {1'b0, rx};
    assign y_abs         = {1'b0, y_pos} + {1'b0, ry};
    assign in_frame      = (x_abs < 11'(FRAME_WIDTH)) && (y_abs < 11'(FRAME_HEIGHT));
    assign write_ok      = in_frame && !(transparent && field == 4'd0);
    assign pixel_address = ADDR_WIDTH'(y_abs) * ADDR_WIDTH'(FRAME_WIDTH) + ADDR_WIDTH'(x_abs);
    assign pixel_value   = PIXEL_WIDTH'(field) + offset;
    assign row_end       = (rx == width - 10'd1);
    assign ry_next       = row_end ? ry + 10'd1 : ry;

    sprite_pixel_unpacker u_unpacker (
        .clock_in   (clock_in),
        .reset_in   (reset_in),
        .load       (byte_load),
        .byte_data  (data_in),
        .bpp_mode   (bpp),
        .step       (draw_step),
        .field      (field),
        .last_field (last_field)
    );

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state                   <= ST_IDLE;
            x_pos                   <= 10'd0;
            y_pos                   <= 10'd0;
            width                   <= 10'd0;
            height                  <= 10'd0;
            bpp                     <= BPP_1;
            offset                  <= '0;
            transparent             <= 1'b0;
            rx                      <= 10'd0;
            ry                      <= 10'd0;
            pixel_write_enable_out  <= 1'b0;
            pixel_write_address_out <= '0;
            pixel_write_data_out    <= '0;
            done_out                <= 1'b0;
        end else if (!enable_in) begin
            state                   <= ST_IDLE;
            pixel_write_enable_out  <= 1'b0;
            pixel_write_address_out <= '0;
            pixel_write_data_out    <= '0;
            done_out                <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (pixel_write_enable_out && pixel_write_ready_in)
                pixel_write_enable_out <= 1'b0;
            case (state)
                ST_IDLE: if (start_in) begin
                    x_pos       <= x_position_in;
                    y_pos       <= y_position_in;
                    width       <= width_in;
                    height      <= height_in;
                    bpp         <= bpp_mode_t'(bpp_mode_in);
                    offset      <= color_palette_offset_in;
                    transparent <= transparent_enable_in;
                    rx          <= 10'd0;
                    ry          <= 10'd0;
                    if (width_in == 10'd0 || height_in == 10'd0) begin
                        state    <= ST_DONE;
                        done_out <= 1'b1;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: if (data_valid_in) state <= ST_DRAW;
                ST_DRAW: begin
                    if (ry == height) begin
                        // Sprite complete; wait for the last write to be taken before signalling.
                        if (out_free) begin
                            done_out <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end else if (out_free) begin
                        pixel_write_enable_out <= write_ok;
                        if (write_ok) begin
                            pixel_write_address_out <= pixel_address;
                            pixel_write_data_out    <= pixel_value;
                        end
                        rx <= row_end ? 10'd0 : rx + 10'd1;
                        ry <= ry_next;
                        if (ry_next != height && last_field)
                            state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised successor to the single-mode sprite drawer. It takes a packed palette-index byte stream over a valid/ready handshake and draws a width×height sprite at a given frame position. It adds 1/2/4-bit modes selected at run time, frame-edge clipping, optional transparency, output backpressure and a done pulse. It sits between the SPI graphics command decoder and the frame-buffer write port.

## Interface
Parameters:
- FRAME_WIDTH, 640, frame-buffer pixels per row
- FRAME_HEIGHT, 400, frame-buffer rows
- PIXEL_WIDTH, 4, palette index bits written to the frame buffer
- ADDR_WIDTH, $clog2(FRAME_WIDTH*FRAME_HEIGHT) = 18, derived, not overridden

Ports:
- clock_in  in  1  system clock
- reset_in  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high)
- enable_in  in  1  low forces IDLE synchronously; any draw in progress is aborted without done_out
- start_in  in  1  one-cycle pulse; latches all geometry/mode inputs
- x_position_in, y_position_in  in  10 each  top-left corner
- width_in, height_in  in  10 each  sprite size in pixels
- bpp_mode_in  in  2  0=1bpp, 1=2bpp, 2=4bpp, 3=treated as 4bpp
- color_palette_offset_in  in  PIXEL_WIDTH  added to each field
- transparent_enable_in  in  1  field value 0 is not written
- data_valid_in / data_ready_out  in/out  1  byte-stream handshake
- data_in  in  8  packed pixel byte
- pixel_write_enable_out  out  1  write valid
- pixel_write_ready_in  in  1  frame-buffer accept
- pixel_write_address_out  out  ADDR_WIDTH  y*FRAME_WIDTH + x
- pixel_write_data_out  out  PIXEL_WIDTH  palette index
- busy_out  out  1  high in every state except IDLE
- done_out  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FETCH, DRAW, DONE.
- IDLE: on start_in, latch all geometry/mode inputs and zero the relative pen (rx, ry). If width or height is 0, go to DONE; otherwise go to FETCH. start_in is ignored in all other states.
- FETCH: data_ready_out=1. On valid&ready, load the byte and set fields = 8/bpp (8, 4 or 2), then go to DRAW.
- DRAW: one field per advance, least-significant field first.
  - value = field + offset, modulo 2^PIXEL_WIDTH.
  - Absolute x = x_position + rx and y = y_position + ry, computed at 11 bits.
  - A write is issued only if x < FRAME_WIDTH, y < FRAME_HEIGHT, and not (transparent_enable and field==0). Otherwise the pixel is skipped: enable stays 0 and the pen still advances.
- Pen advance: rx+1; at rx = width-1, set rx=0 and ry+1. Bytes may straddle rows.
- After each field: if ry reached height, go to DONE and discard the byte's remaining fields. Else if fields is exhausted, go to FETCH. Else stay in DRAW.
- DONE: done_out=1 for one cycle, then go to IDLE.
- enable_in low: go to IDLE next edge, drop pixel_write_enable_out and data_ready_out, no done_out.

## Timing
- Reset values: all outputs 0, state IDLE, pen 0.
- start_in at cycle 0 puts data_ready_out=1 in cycle 1.
- Byte accepted at edge n puts the first pixel's enable/address/data registered at edge n+1.
- Outputs are registered. When pixel_write_enable_out=1 and pixel_write_ready_in=0, address, data, enable, pen and state all hold. Skipped pixels advance regardless of ready.
- Throughput: one field per cycle, plus one FETCH cycle per byte (1bpp: 8 px per 9 cycles).
- done_out asserts the cycle after the final write is accepted, or after the final skip.
- Backpressure never stalls the input handshake beyond FETCH.

## Structure
- graphics_pkg: bpp_mode_t enum, sprite_state_t, FRAME_WIDTH/FRAME_HEIGHT defaults.
- Sub-module sprite_pixel_unpacker: byte shift register plus field counter. It outputs the current field and a last_field flag, and advances on a step strobe.

## Test plan
- 1bpp, x=0,y=0,w=8,h=1, offset 2, byte 0xA5 → 8 writes at addresses 0..7, data 3,2,3,2,2,3,2,3; done_out one cycle after the 8th.
- 4bpp, w=3,h=2 at (10,5), bytes 0x21,0x43,0x65 → writes at 3210,3211,3212,3850,3851,3852 with data 1..6; two fields consumed per byte.
- 2bpp, x=639, w=4,h=1, byte 0xE4 → exactly one write at address 639 with data 0; three skipped pixels; done_out still pulses.
- Transparency on, 4bpp, byte 0x30 → low field 0 skipped, one write with data 3.
- Hold pixel_write_ready_in low for 5 cycles mid-sprite → outputs stable, no pixel lost or duplicated.
- Abort and reset: drop enable_in, or assert reset_in asynchronously, during DRAW → IDLE, all outputs 0, no done_out; a new start_in is then accepted.
